// File: rtl/lcd_text_fetch_ctrl_if.sv
// Character RAM, font ROM and host write bus for the text fetch sequencer.
//   master : the fetch sequencer (drives RAM/ROM addresses, strobes and wr_ack)
//   slave  : the memories and the host write port
// Signals:
//   char_addr/char_rd/char_rdata  character RAM read (rdata one cycle after char_rd)
//   char_we/char_wdata            character RAM write
//   font_addr/font_data           font ROM (data one cycle after address)
//   wr_req/wr_addr/wr_data/wr_ack host write request, held until wr_ack
interface lcd_text_fetch_ctrl_if;
   logic [9:0]  char_addr;
   logic        char_rd;
   logic [7:0]  char_rdata;
   logic        char_we;
   logic [7:0]  char_wdata;
   logic [10:0] font_addr;
   logic [7:0]  font_data;
   logic        wr_req;
   logic [9:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        wr_ack;

   modport master (
      output char_addr, char_rd, char_we, char_wdata, font_addr, wr_ack,
      input  char_rdata, font_data, wr_req, wr_addr, wr_data
   );

   modport slave (
      input  char_addr, char_rd, char_we, char_wdata, font_addr, wr_ack,
      output char_rdata, font_data, wr_req, wr_addr, wr_data
   );
endinterface

// File: rtl/lcd_text_fetch_ctrl.sv
// Text-mode fetch sequencer for the LCD character renderer.
// Looks three pixels ahead of the raster, reads the character code of the next
// 8-pixel cell, addresses the 8x16 glyph row in the font ROM and shifts the
// font byte out one bit per pixel. Host writes share the single-port character
// RAM and only use cycles the display fetch does not need.
// Ports:
//   CLK_PIX, nRST      pixel clock, asynchronous active-low reset
//   horizontal         raster x (0..H_TOTAL-1)
//   vertical           raster y (0..V_TOTAL-1)
//   bus                character RAM / font ROM / host write bus (master side)
//   pixel_on, de       registered pixel and active-video flag, one cycle after
//                      the horizontal value they describe
module lcd_text_fetch_ctrl #(
   parameter int unsigned H_TOTAL  = 525,
   parameter int unsigned H_ACTIVE = 480,
   parameter int unsigned V_TOTAL  = 286,
   parameter int unsigned V_ACTIVE = 272,
   parameter int unsigned COLS     = 60,
   parameter int unsigned ROWS     = 17
) (
   input  logic                        CLK_PIX,
   input  logic                        nRST,
   input  logic [10:0]                 horizontal,
   input  logic [9:0]                  vertical,
   lcd_text_fetch_ctrl_if.master       bus,
   output logic                        pixel_on,
   output logic                        de
);

   typedef enum logic [1:0] {StIdle, StCharRd, StFontRd, StLoad} state_e;

   state_e      state_q, state_d;
   logic [11:0] h_sum, hn;
   logic        h_wrap;
   logic [9:0]  vn;
   logic [5:0]  row;
   logic [6:0]  col;
   logic [9:0]  cell_addr;
   logic        trig_pos, trigger, wr_grant, de_d;
   logic [9:0]  fetch_addr_q;
   logic [3:0]  glyph_row_q;
   logic [10:0] font_addr_q;
   logic [7:0]  shreg_q, shift_src;
   logic        pixel_on_q, de_q, run_q;

   // Lookahead position: the cell starting at hn is fetched three cycles early.
   always_comb begin
      h_sum  = {1'b0, horizontal} + 12'd3;
      h_wrap = h_sum >= 12'(H_TOTAL);
      hn     = h_wrap ? h_sum - 12'(H_TOTAL) : h_sum;
      vn     = vertical;
      if (h_wrap) begin
         vn = (vertical == 10'(V_TOTAL - 1)) ? 10'd0 : vertical + 10'd1;
      end
      row       = vn[9:4];
      col       = hn[9:3];
      cell_addr = 10'({4'd0, row} * 10'(COLS)) + {3'd0, col};
      trig_pos  = (hn[2:0] == 3'd0) && (hn < 12'(H_ACTIVE)) && (vn < 10'(V_ACTIVE)) &&
                  (row < 6'(ROWS));
      trigger   = (state_q == StIdle) && trig_pos;
   end

   // State register
   always_ff @(posedge CLK_PIX or negedge nRST) begin
      if (!nRST) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (trig_pos) state_d = StCharRd;
         StCharRd: state_d = StFontRd;
         StFontRd: state_d = StLoad;
         StLoad:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Output logic; run_q keeps a request held across reset from being acked
   // in the release cycle.
   always_comb begin
      wr_grant       = run_q && bus.wr_req && (state_q != StCharRd) && !trigger;
      bus.char_rd    = 1'b0;
      bus.char_we    = 1'b0;
      bus.char_addr  = 10'd0;
      bus.char_wdata = 8'd0;
      bus.wr_ack     = 1'b0;
      bus.font_addr  = font_addr_q;
      unique case (state_q)
         StCharRd: begin
            bus.char_rd   = 1'b1;
            bus.char_addr = fetch_addr_q;
         end
         StFontRd: bus.font_addr = {bus.char_rdata[6:0], glyph_row_q};
         default: ;
      endcase
      if (wr_grant) begin
         bus.char_we    = 1'b1;
         bus.char_addr  = bus.wr_addr;
         bus.char_wdata = bus.wr_data;
         bus.wr_ack     = 1'b1;
      end
   end

   // In LOAD the fresh font byte bypasses the shift register so pixel 0 of the
   // cell leaves on the same edge the byte is captured.
   always_comb begin
      shift_src = (state_q == StLoad) ? bus.font_data : shreg_q;
      de_d      = (horizontal < 11'(H_ACTIVE)) && (vertical < 10'(V_ACTIVE));
   end

   always_ff @(posedge CLK_PIX or negedge nRST) begin
      if (!nRST) begin
         run_q        <= 1'b0;
         fetch_addr_q <= 10'd0;
         glyph_row_q  <= 4'd0;
         font_addr_q  <= 11'd0;
         shreg_q      <= 8'd0;
         pixel_on_q   <= 1'b0;
         de_q         <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (trigger) begin
            fetch_addr_q <= cell_addr;
            glyph_row_q  <= vn[3:0];
         end
         font_addr_q <= bus.font_addr;
         shreg_q     <= {shift_src[6:0], 1'b0};
         pixel_on_q  <= shift_src[7] && de_d;
         de_q        <= de_d;
      end
   end

   assign pixel_on = pixel_on_q;
   assign de       = de_q;

endmodule

// File: tb/tb_lcd_text_fetch_ctrl.sv
module tb_lcd_text_fetch_ctrl;
   localparam int H_TOTAL  = 525;
   localparam int H_ACTIVE = 480;
   localparam int V_TOTAL  = 286;
   localparam int V_ACTIVE = 272;

   logic        CLK_PIX;
   logic        nRST;
   logic [10:0] horizontal;
   logic [9:0]  vertical;
   logic        pixel_on, de;

   lcd_text_fetch_ctrl_if bus ();

   lcd_text_fetch_ctrl dut (
      .CLK_PIX    (CLK_PIX),
      .nRST       (nRST),
      .horizontal (horizontal),
      .vertical   (vertical),
      .bus        (bus),
      .pixel_on   (pixel_on),
      .de         (de)
   );

   initial CLK_PIX = 1'b0;
   always #5 CLK_PIX = ~CLK_PIX;

   // Memory models
   logic [7:0] mem [1024];
   logic       init_en;

   function automatic logic [7:0] init_val(int i);
      case (i)
         0:       return 8'h41;
         125:     return 8'hC3;
         1019:    return 8'h2E;
         default: return 8'(i * 37 + 11);
      endcase
   endfunction

   function automatic logic [7:0] rom_f(logic [10:0] a);
      if (a == 11'h410) return 8'h18;
      return 8'(int'(a) * 29) ^ {1'b0, a[10:4]};
   endfunction

   always @(posedge CLK_PIX) begin
      if (init_en) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      end else if (bus.char_we) begin
         mem[bus.char_addr] <= bus.char_wdata;
      end
      if (bus.char_rd) bus.char_rdata <= mem[bus.char_addr];
      bus.font_data <= rom_f(bus.font_addr);
   end

   // Golden pixel from the character RAM contents
   function automatic logic exp_pix(int x, int y);
      logic [7:0] c, g;
      c = mem[10'((y / 16) * 60 + x / 8)];
      g = rom_f({c[6:0], 4'(y % 16)});
      return g[7 - (x % 8)];
   endfunction

   int n_chk, n_fail;
   int hc, vc, ph, pv, settle;
   logic       st_rst, st_req;
   logic [9:0] st_waddr;
   logic [7:0] st_wdata;

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (h=%0d v=%0d)", name, act, exp, hc, vc);
      end
   endtask

   // One pixel clock: advance raster and staged inputs at negedge, sample 3 later.
   task automatic step();
      @(negedge CLK_PIX);
      if (hc == H_TOTAL - 1) begin
         hc = 0;
         vc = (vc == V_TOTAL - 1) ? 0 : vc + 1;
      end else begin
         hc++;
      end
      horizontal   = 11'(hc);
      vertical     = 10'(vc);
      nRST         = st_rst;
      bus.wr_req   = st_req;
      bus.wr_addr  = st_waddr;
      bus.wr_data  = st_wdata;
      #3;
      if (settle > 0) settle--;
      chk("rd_ack_overlap", 32'(bus.char_rd & bus.wr_ack), 0);
      if (settle == 0) begin
         if (ph < H_ACTIVE && pv < V_ACTIVE) begin
            chk("pixel", 32'(pixel_on), 32'(exp_pix(ph, pv)));
            chk("de", 32'(de), 1);
         end else begin
            chk("pixel_blank", 32'(pixel_on), 0);
            chk("de_blank", 32'(de), 0);
         end
      end
      ph = hc;
      pv = vc;
   endtask

   // Jump the raster to n pixels before (h,v) and run up to it.
   task automatic goto(int h, int v, int n);
      hc = h;
      vc = v;
      for (int i = 0; i < n; i++) begin
         if (hc == 0) begin
            hc = H_TOTAL - 1;
            vc = (vc == 0) ? V_TOTAL - 1 : vc - 1;
         end else begin
            hc--;
         end
      end
      settle = 24;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk_zero(string name);
      chk({name, "_char_rd"}, 32'(bus.char_rd), 0);
      chk({name, "_char_we"}, 32'(bus.char_we), 0);
      chk({name, "_wr_ack"}, 32'(bus.wr_ack), 0);
      chk({name, "_char_addr"}, 32'(bus.char_addr), 0);
      chk({name, "_char_wdata"}, 32'(bus.char_wdata), 0);
      chk({name, "_font_addr"}, 32'(bus.font_addr), 0);
      chk({name, "_pixel_on"}, 32'(pixel_on), 0);
      chk({name, "_de"}, 32'(de), 0);
   endtask

   typedef struct {
      int          h;
      int          v;
      logic        rd;
      logic [9:0]  addr;
      logic        chk_font;
      logic [10:0] font;
   } vec_t;

   vec_t vecs [11];

   initial begin
      logic [7:0] pat;
      int w;
      n_chk = 0; n_fail = 0;
      vecs[0]  = '{h: 523, v: 285, rd: 1'b1, addr: 10'd0,    chk_font: 1'b0, font: 11'h000};
      vecs[1]  = '{h: 524, v: 285, rd: 1'b0, addr: 10'd0,    chk_font: 1'b1, font: 11'h410};
      vecs[2]  = '{h: 38,  v: 37,  rd: 1'b1, addr: 10'd125,  chk_font: 1'b0, font: 11'h000};
      vecs[3]  = '{h: 39,  v: 37,  rd: 1'b0, addr: 10'd0,    chk_font: 1'b1, font: 11'h435};
      vecs[4]  = '{h: 470, v: 271, rd: 1'b1, addr: 10'd1019, chk_font: 1'b0, font: 11'h000};
      vecs[5]  = '{h: 471, v: 271, rd: 1'b0, addr: 10'd0,    chk_font: 1'b1, font: 11'h2EF};
      vecs[6]  = '{h: 523, v: 271, rd: 1'b0, addr: 10'd0,    chk_font: 1'b0, font: 11'h000};
      vecs[7]  = '{h: 470, v: 272, rd: 1'b0, addr: 10'd0,    chk_font: 1'b0, font: 11'h000};
      vecs[8]  = '{h: 6,   v: 0,   rd: 1'b1, addr: 10'd1,    chk_font: 1'b0, font: 11'h000};
      vecs[9]  = '{h: 478, v: 10,  rd: 1'b0, addr: 10'd0,    chk_font: 1'b0, font: 11'h000};
      vecs[10] = '{h: 518, v: 20,  rd: 1'b0, addr: 10'd0,    chk_font: 1'b0, font: 11'h000};

      nRST = 1'b0; st_rst = 1'b0; st_req = 1'b0; st_waddr = '0; st_wdata = '0;
      bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.char_rdata = '0; bus.font_data = '0;
      init_en = 1'b1;
      hc = 520; vc = 3; ph = hc; pv = vc;
      horizontal = 11'(hc); vertical = 10'(vc);
      settle = 1000;

      // Power-on reset with the raster running
      for (int i = 0; i < 3; i++) begin
         step();
         chk_zero("por");
      end
      init_en = 1'b0;
      st_rst = 1'b1;
      settle = 30;
      for (int i = 0; i < 2000 && !(hc == 99 && vc == 5); i++) step();

      // Reset pulse at horizontal=100 for three cycles with a write pending
      st_rst = 1'b0; st_req = 1'b1; st_waddr = 10'd5; st_wdata = 8'h77;
      settle = 1000;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_zero("rst_mid");
      end
      st_rst = 1'b1; st_req = 1'b0;
      settle = 11;
      step();
      chk("rst_release_ack", 32'(bus.wr_ack), 0);
      for (int i = 0; i < 100; i++) step();
      chk("dropped_write", 32'(mem[5]), 32'(init_val(5)));

      // Glyph 'A' row 0 at the top-left cell: 0,0,0,1,1,0,0,0
      pat = 8'h18;
      goto(1, 0, 30);
      for (int x = 0; x < 8; x++) begin
         chk("A_row0_px", 32'(pixel_on), 32'(pat[7 - x]));
         step();
      end

      // Fetch address vectors
      for (int i = 0; i < 11; i++) begin
         goto(vecs[i].h, vecs[i].v, 12);
         chk("vec_char_rd", 32'(bus.char_rd), 32'(vecs[i].rd));
         if (vecs[i].rd) chk("vec_char_addr", 32'(bus.char_addr), 32'(vecs[i].addr));
         if (vecs[i].chk_font) chk("vec_font_addr", 32'(bus.font_addr), 32'(vecs[i].font));
      end

      // Write requested exactly on a trigger cycle: waits out CHAR_RD
      goto(52, 0, 16);
      settle = 1000;
      st_req = 1'b1; st_waddr = 10'd7; st_wdata = 8'h5A;
      step();
      chk("coll_trig_we", 32'(bus.char_we), 0);
      chk("coll_trig_ack", 32'(bus.wr_ack), 0);
      step();
      chk("coll_charrd_rd", 32'(bus.char_rd), 1);
      chk("coll_charrd_ack", 32'(bus.wr_ack), 0);
      step();
      chk("coll_ack", 32'(bus.wr_ack), 1);
      chk("coll_we", 32'(bus.char_we), 1);
      chk("coll_addr", 32'(bus.char_addr), 7);
      chk("coll_wdata", 32'(bus.char_wdata), 32'h5A);
      st_req = 1'b0;
      step();
      goto(55, 0, 40);
      chk("Z_font_addr", 32'(bus.font_addr), 32'h5A0);
      for (int i = 0; i < 20; i++) step();

      // Burst of 20 held writes during active video
      goto(100, 1, 60);
      for (int i = 0; i < 20; i++) begin
         st_req = 1'b1; st_waddr = 10'(960 + i); st_wdata = 8'(8'h30 + i);
         step();
         w = 0;
         while (!bus.wr_ack && w < 4) begin
            step();
            w++;
         end
         chk("burst_wait", (w <= 2) ? 1 : 0, 1);
      end
      st_req = 1'b0;
      step();
      step();
      for (int i = 0; i < 20; i++) chk("burst_mem", 32'(mem[960 + i]), 32'h30 + i);
      for (int i = 0; i < 40; i++) step();

      // Vertical blanking: no fetch, immediate write acks
      goto(10, 275, 16);
      for (int i = 0; i < 6; i++) begin
         st_req = 1'b1; st_waddr = 10'(300 + i); st_wdata = 8'(8'h60 + i);
         step();
         chk("blank_ack", 32'(bus.wr_ack), 1);
         chk("blank_rd", 32'(bus.char_rd), 0);
         st_req = 1'b0;
         step();
         chk("blank_idle_ack", 32'(bus.wr_ack), 0);
         chk("blank_idle_rd", 32'(bus.char_rd), 0);
      end
      step();
      for (int i = 0; i < 6; i++) chk("blank_mem", 32'(mem[300 + i]), 32'h60 + i);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
